// File: rtl/chan_extract_pkg.sv
// Shared types and constants for the single-channel extractor that sits behind
// the M=2048 channelizer.
`timescale 1ns/1ps
package chan_extract_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_TUSER_WIDTH = 24;
  localparam int DEF_CHAN_WIDTH  = 11;
  localparam int DEF_FIFO_AW     = 10;
  localparam int DEF_LEN_WIDTH   = 16;

  // One FIFO entry is {tlast_bit, tdata}.
  localparam int FIFO_W = DEF_DATA_WIDTH + 1;

  localparam logic [15:0] OVF_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  function automatic int fifo_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/chan_single_extract_if.sv
// AXI-Stream bundle used on both sides of the extractor.
`timescale 1ns/1ps
interface chan_single_extract_if
  import chan_extract_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int TUSER_WIDTH = DEF_TUSER_WIDTH
);
  logic                   tvalid;
  logic                   tready;
  logic [DATA_WIDTH-1:0]  tdata;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tlast;

  modport master (
    output tvalid,
    output tdata,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tuser,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/chan_extract_fifo.sv
// First-word-fall-through FIFO: registered RAM read straight into the output
// register; occupancy counts every word held, including the output register.
`timescale 1ns/1ps
module chan_extract_fifo #(
  parameter int FIFO_AW = chan_extract_pkg::DEF_FIFO_AW,
  parameter int FIFO_W  = chan_extract_pkg::FIFO_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [FIFO_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_rd_valid,
  output logic [FIFO_W-1:0] o_rd_data,
  input  logic              i_rd_ready
);

  localparam logic [FIFO_AW:0] DEPTH   = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

  logic [FIFO_W-1:0]  r_mem [2**FIFO_AW];
  logic [FIFO_AW:0]   r_wr_ptr;
  logic [FIFO_AW:0]   r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_out_valid;
  logic [FIFO_W-1:0]  r_out_data;

  logic w_full;
  logic w_rd_xfer;
  logic w_wr;
  logic w_mem_empty;
  logic w_load;

  assign w_full      = (r_count == DEPTH);
  assign w_rd_xfer   = r_out_valid & i_rd_ready;
  // A word leaving the output register frees a slot in the same cycle.
  assign o_wr_ready  = ~w_full | w_rd_xfer;
  assign w_wr        = i_wr_en & o_wr_ready;
  assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
  assign w_load      = ~w_mem_empty & (~r_out_valid | i_rd_ready);

  assign o_rd_valid = r_out_valid;
  assign o_rd_data  = r_out_data;

  // NOTE: the storage array has no reset so it maps onto block RAM; the
  // pointers and occupancy alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[FIFO_AW-1:0]] <= i_wr_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end

      if (w_load) begin
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
        r_out_data <= r_mem[r_rd_ptr[FIFO_AW-1:0]];
      end

      if (w_load) begin
        r_out_valid <= 1'b1;
      end else if (w_rd_xfer) begin
        r_out_valid <= 1'b0;
      end

      case ({w_wr, w_rd_xfer})
        2'b10:   r_count <= r_count + PTR_ONE;
        2'b01:   r_count <= r_count - PTR_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/chan_single_extract.sv
// Pulls one channel out of the channelizer's interleaved stream and re-emits it
// as fixed-length AXI-Stream packets; never stalls the channelizer.
`timescale 1ns/1ps
module chan_single_extract
  import chan_extract_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int TUSER_WIDTH = DEF_TUSER_WIDTH,
  parameter int CHAN_WIDTH  = DEF_CHAN_WIDTH,
  parameter int FIFO_AW     = DEF_FIFO_AW,
  parameter int LEN_WIDTH   = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  async_reset_n,
  input  logic                  enable_i,
  input  logic [CHAN_WIDTH-1:0] chan_sel,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  chan_single_extract_if.slave  s_axis,
  chan_single_extract_if.master m_axis,
  output logic [15:0]           ovf_cnt,
  output logic                  busy_o
);

  localparam int ENTRY_W = fifo_width(DATA_WIDTH);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic                  r_busy;
  logic                  r_s_tready;
  logic [CHAN_WIDTH-1:0] r_chan_sel;
  logic [LEN_WIDTH-1:0]  r_pkt_len;
  logic [LEN_WIDTH-1:0]  r_wr_cnt;
  logic [15:0]           r_ovf_cnt;

  logic               w_match;
  logic               w_last_bit;
  logic               w_wr_en;
  logic [ENTRY_W-1:0] w_wr_data;
  logic               w_fifo_wr_ready;
  logic               w_drop;
  logic               w_rd_valid;
  logic [ENTRY_W-1:0] w_rd_data;
  logic               w_unused_tuser;

  assign w_match    = s_axis.tvalid & (s_axis.tuser[CHAN_WIDTH-1:0] == r_chan_sel);
  assign w_last_bit = (r_wr_cnt == (r_pkt_len - LEN_ONE));
  assign w_drop     = (r_state == RUN) & w_match & ~w_fifo_wr_ready;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it holding a value (which would be a latch).
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_data = '0;
    case (r_state)
      RUN: begin
        if (w_match) begin
          w_wr_en   = w_fifo_wr_ready;
          w_wr_data = {w_last_bit, s_axis.tdata};
        end
      end
      FLUSH: begin
        // Pad the partial packet with zero words so downstream still sees pkt_len.
        if (r_wr_cnt != '0) begin
          w_wr_en   = w_fifo_wr_ready;
          w_wr_data = {w_last_bit, {DATA_WIDTH{1'b0}}};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_s_tready <= 1'b0;
      r_chan_sel <= '0;
      r_pkt_len  <= '0;
    end else begin
      r_s_tready <= 1'b1;
      case (r_state)
        IDLE: begin
          if (enable_i) begin
            r_chan_sel <= chan_sel;
            r_pkt_len  <= pkt_len;
            r_state    <= SYNC;
            r_busy     <= 1'b1;
          end
        end
        SYNC: begin
          if (!enable_i) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (s_axis.tvalid && s_axis.tlast) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!enable_i) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (r_wr_cnt == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Dropped words never touch wr_cnt, so every packet holds exactly pkt_len writes.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      r_wr_cnt  <= '0;
      r_ovf_cnt <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_wr_cnt <= '0;
      end else if (w_wr_en) begin
        r_wr_cnt <= w_last_bit ? '0 : (r_wr_cnt + LEN_ONE);
      end

      if (w_drop && (r_ovf_cnt != OVF_MAX)) begin
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
    end
  end

  chan_extract_fifo #(
    .FIFO_AW (FIFO_AW),
    .FIFO_W  (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (async_reset_n),
    .i_wr_en    (w_wr_en),
    .i_wr_data  (w_wr_data),
    .o_wr_ready (w_fifo_wr_ready),
    .o_rd_valid (w_rd_valid),
    .o_rd_data  (w_rd_data),
    .i_rd_ready (m_axis.tready)
  );

  assign s_axis.tready = r_s_tready;
  assign m_axis.tvalid = w_rd_valid;
  assign m_axis.tdata  = w_rd_data[DATA_WIDTH-1:0];
  assign m_axis.tlast  = w_rd_data[DATA_WIDTH];
  assign m_axis.tuser  = '0;
  assign ovf_cnt       = r_ovf_cnt;
  assign busy_o        = r_busy;

  // Upper tuser bits carry channelizer metadata this block has no use for.
  assign w_unused_tuser = ^s_axis.tuser[TUSER_WIDTH-1:CHAN_WIDTH];

endmodule

// File: tb/tb_chan_single_extract.sv
// Self-checking bench for chan_single_extract: table-driven extraction runs
// plus hand-written SYNC, flush, back-pressure and async-reset sequences.
`timescale 1ns/1ps
module tb_chan_single_extract;
  import chan_extract_pkg::*;

  localparam int DW = 32;
  localparam int UW = 24;
  localparam int CW = 11;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          async_reset_n;
  logic          enable_i;
  logic [CW-1:0] chan_sel;
  logic [LW-1:0] pkt_len;
  logic [15:0]   ovf_cnt;
  logic          busy_o;

  chan_single_extract_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_axis ();
  chan_single_extract_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_axis ();

  chan_single_extract #(
    .DATA_WIDTH (DW),
    .TUSER_WIDTH(UW),
    .CHAN_WIDTH (CW),
    .FIFO_AW    (10),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk          (clk),
    .async_reset_n(async_reset_n),
    .enable_i     (enable_i),
    .chan_sel     (chan_sel),
    .pkt_len      (pkt_len),
    .s_axis       (s_axis),
    .m_axis       (m_axis),
    .ovf_cnt      (ovf_cnt),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] chan;
    logic [LW-1:0] len;
    int            frame_len;
    int            frames;
    bit            tready;
    int            exp_words;
    int            exp_pkts;
    int            exp_ovf;
  } vec_t;

  int            checks = 0;
  int            failures = 0;
  logic [DW:0]   sb[$];
  int            rx_words = 0;
  int            rx_pkts = 0;
  bit            mon_en = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW:0]   prev_word;
  bit            bp_mode = 1'b0;
  int            bp_phase = 0;
  logic [CW-1:0] cur_chan;
  logic [LW-1:0] cur_len;
  logic [LW-1:0] m_cnt;
  int            model_drops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tuser  = '0;
    s_axis.tdata  = '0;
  endtask

  // Reference packetiser: one expected entry per accepted write, 1024-word capacity.
  task automatic push_expected(input logic [DW-1:0] data);
    logic last;
    last = (m_cnt == cur_len - 16'd1);
    if (sb.size() >= 1024) begin
      model_drops++;
    end else begin
      sb.push_back({last, data});
      m_cnt = last ? '0 : m_cnt + 16'd1;
    end
  endtask

  task automatic drive_word(input int idx, input bit last, input int frame, input bit capture);
    s_axis.tvalid = 1'b1;
    s_axis.tuser  = UW'(idx);
    s_axis.tdata  = {16'(idx), 16'(frame)};
    s_axis.tlast  = last;
    if (capture && (CW'(idx) == cur_chan)) push_expected(s_axis.tdata);
    tick();
  endtask

  task automatic drive_frames(input int frame_len, input int first, input int count, input bit capture);
    for (int f = first; f < first + count; f++) begin
      for (int i = 0; i < frame_len; i++) drive_word(i, i == frame_len - 1, f, capture);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    repeat (4) tick();
  endtask

  task automatic do_reset();
    mon_en  = 1'b0;
    bp_mode = 1'b0;
    idle_inputs();
    enable_i      = 1'b0;
    async_reset_n = 1'b0;
    repeat (2) tick();
    #3;
    async_reset_n = 1'b1;
    tick();
    sb.delete();
    rx_words    = 0;
    rx_pkts     = 0;
    model_drops = 0;
    m_cnt       = '0;
    mon_en      = 1'b1;
  endtask

  task automatic start_run(input logic [CW-1:0] ch, input logic [LW-1:0] len, input bit rdy);
    cur_chan      = ch;
    cur_len       = len;
    chan_sel      = ch;
    pkt_len       = len;
    m_axis.tready = rdy;
    enable_i      = 1'b1;
    tick();
  endtask

  // Output monitor: scoreboard pops and hold-while-stalled checks, sampled on negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 64'(m_axis.tvalid), 64'd1);
          check("hold_word", 64'({m_axis.tlast, m_axis.tdata}), 64'(prev_word));
        end
        if (m_axis.tvalid && m_axis.tready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual=%0h expected=none at %0t",
                     {m_axis.tlast, m_axis.tdata}, $time);
          end else begin
            check("sb_word", 64'({m_axis.tlast, m_axis.tdata}), 64'(sb.pop_front()));
          end
          rx_words++;
          if (m_axis.tlast) rx_pkts++;
        end
        prev_stall = m_axis.tvalid && !m_axis.tready;
        prev_word  = {m_axis.tlast, m_axis.tdata};
      end
    end
  end

  // Downstream ready pattern: 50 ns high, 100 ns low.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        m_axis.tready = (bp_phase < 5);
        bp_phase      = (bp_phase == 14) ? 0 : bp_phase + 1;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    int   n;

    vecs[0] = '{11'd5, 16'd4,  2048, 8,    1'b1, 8,    2,  0};
    vecs[1] = '{11'd3, 16'd1,  8,    5,    1'b1, 5,    5,  0};
    vecs[2] = '{11'd7, 16'd3,  8,    6,    1'b1, 6,    2,  0};
    vecs[3] = '{11'd0, 16'd16, 4,    1030, 1'b0, 1024, 64, 6};

    // Reset state while reset is held, then tready on the first edge after release.
    idle_inputs();
    enable_i      = 1'b0;
    chan_sel      = '0;
    pkt_len       = 16'd1;
    m_axis.tready = 1'b0;
    async_reset_n = 1'b0;
    #2;
    check("rst_m_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_axis.tdata), 64'd0);
    check("rst_m_tlast", 64'(m_axis.tlast), 64'd0);
    check("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_s_tready", 64'(s_axis.tready), 64'd0);
    @(posedge clk);
    #4;
    async_reset_n = 1'b1;
    tick();
    check("s_tready_after_rst", 64'(s_axis.tready), 64'd1);
    check("busy_after_rst", 64'(busy_o), 64'd0);

    // Table-driven extraction runs.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      start_run(vecs[r].chan, vecs[r].len, vecs[r].tready);
      drive_frames(vecs[r].frame_len, 0, 1, 1'b0);
      check($sformatf("busy_run_%0d", r), 64'(busy_o), 64'd1);
      drive_frames(vecs[r].frame_len, 1, vecs[r].frames, 1'b1);
      idle_inputs();
      repeat (2) tick();
      check($sformatf("ovf_%0d", r), 64'(ovf_cnt), 64'(vecs[r].exp_ovf));
      check($sformatf("s_tready_%0d", r), 64'(s_axis.tready), 64'd1);
      m_axis.tready = 1'b1;
      wait_drain(2000);
      check($sformatf("words_%0d", r), 64'(rx_words), 64'(vecs[r].exp_words));
      check($sformatf("pkts_%0d", r), 64'(rx_pkts), 64'(vecs[r].exp_pkts));
      enable_i = 1'b0;
      repeat (4) tick();
      check($sformatf("idle_%0d", r), 64'(busy_o), 64'd0);
    end

    // SYNC alignment: enable arrives mid-frame; the rest of that frame is discarded.
    do_reset();
    cur_chan      = 11'd1500;
    cur_len       = 16'd1;
    chan_sel      = 11'd1500;
    pkt_len       = 16'd1;
    m_axis.tready = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      if (i == 1000) enable_i = 1'b1;
      drive_word(i, i == 2047, 0, 1'b0);
    end
    drive_frames(2048, 1, 1, 1'b1);
    idle_inputs();
    wait_drain(100);
    check("sync_words", 64'(rx_words), 64'd1);
    enable_i = 1'b0;
    repeat (4) tick();

    // Flush padding: 13 real words with pkt_len=10 leave 3 in packet 2.
    do_reset();
    start_run(11'd2, 16'd10, 1'b1);
    drive_frames(4, 0, 1, 1'b0);
    drive_frames(4, 1, 13, 1'b1);
    idle_inputs();
    enable_i = 1'b0;
    for (int k = 0; k < 16 && m_cnt != '0; k++) push_expected('0);
    n = 0;
    while (busy_o && n < 50) begin
      tick();
      n++;
    end
    check("flush_idle", 64'(busy_o), 64'd0);
    wait_drain(200);
    check("flush_words", 64'(rx_words), 64'd20);
    check("flush_pkts", 64'(rx_pkts), 64'd2);

    // Back-pressure with a mid-run config change that must be ignored.
    do_reset();
    start_run(11'd1, 16'd3, 1'b0);
    drive_frames(4, 0, 1, 1'b0);
    chan_sel = 11'd2;
    pkt_len  = 16'd7;
    bp_phase = 0;
    bp_mode  = 1'b1;
    drive_frames(4, 1, 30, 1'b1);
    idle_inputs();
    wait_drain(600);
    bp_mode       = 1'b0;
    m_axis.tready = 1'b1;
    check("bp_words", 64'(rx_words), 64'd30);
    check("bp_pkts", 64'(rx_pkts), 64'd10);
    enable_i = 1'b0;
    repeat (4) tick();

    // Async reset mid-packet, asserted between clock edges.
    do_reset();
    start_run(11'd1, 16'd4, 1'b0);
    drive_frames(4, 0, 1, 1'b0);
    drive_frames(4, 1, 6, 1'b1);
    idle_inputs();
    tick();
    check("pre_rst_valid", 64'(m_axis.tvalid), 64'd1);
    check("pre_rst_busy", 64'(busy_o), 64'd1);
    mon_en = 1'b0;
    #2;
    async_reset_n = 1'b0;
    #1;
    check("arst_m_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("arst_m_tdata", 64'(m_axis.tdata), 64'd0);
    check("arst_m_tlast", 64'(m_axis.tlast), 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_s_tready", 64'(s_axis.tready), 64'd0);
    enable_i = 1'b0;
    #3;
    async_reset_n = 1'b1;
    #1;
    check("arst_tready_before_edge", 64'(s_axis.tready), 64'd0);
    @(posedge clk);
    #1;
    check("arst_tready_after_edge", 64'(s_axis.tready), 64'd1);
    sb.delete();
    rx_words = 0;
    rx_pkts  = 0;
    mon_en   = 1'b1;
    m_axis.tready = 1'b1;
    repeat (4) tick();
    check("arst_fifo_empty", 64'(m_axis.tvalid), 64'd0);
    check("arst_no_words", 64'(rx_words), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chan_single_extract.md
Name: chan_single_extract

Overview:
- Sits directly downstream of the M=2048 PFB channelizer top (chan_top_2048M_16iw_16ow_32tps).
- Takes the channelizer's interleaved output stream, keeps only the samples of one selected channel, and buffers them in an internal FIFO.
- Emits fixed-length AXI-Stream packets of that channel's I/Q samples, with tlast on the last word of each packet.
- Never back-pressures the channelizer. When the FIFO is full, samples are dropped and counted.

Parameters:
- DATA_WIDTH, 32, I/Q sample width (I in [31:16], Q in [15:0]).
- TUSER_WIDTH, 24, channelizer tuser width.
- CHAN_WIDTH, 11, channel index width; the index is carried in s_axis_tuser[CHAN_WIDTH-1:0].
- FIFO_AW, 10, FIFO address width; depth is 2^FIFO_AW = 1024.
- LEN_WIDTH, 16, packet length width.

Ports:
- clk  in  1  Single clock.
- async_reset_n  in  1  Asynchronous, active-low reset.
- enable_i  in  1  Run request.
- chan_sel  in  CHAN_WIDTH  Channel to extract. Latched on entry to SYNC.
- pkt_len  in  LEN_WIDTH  Words per output packet, must be >=1. Latched on entry to SYNC.
- s_axis_tvalid  in  1  Channelizer output valid.
- s_axis_tdata  in  DATA_WIDTH  Channelizer sample.
- s_axis_tuser  in  TUSER_WIDTH  Channel index in the LSBs.
- s_axis_tlast  in  1  End of channelizer frame.
- s_axis_tready  out  1  Ready to channelizer.
- m_axis_tvalid  out  1  Output valid.
- m_axis_tdata  out  DATA_WIDTH  Extracted sample.
- m_axis_tlast  out  1  Last word of packet.
- m_axis_tready  in  1  Downstream ready.
- ovf_cnt  out  16  Saturating count of dropped samples.
- busy_o  out  1  High in any state other than IDLE.

Behaviour:
- Reset values: every output is 0 except s_axis_tready, which is 1 from the first clock edge after reset release. FSM is in IDLE, FIFO is empty, all counters are 0.
- s_axis_tready stays 1 at all times outside reset; the block never stalls the channelizer.
- Input match: a word matches when s_axis_tvalid=1 and s_axis_tuser[CHAN_WIDTH-1:0]==chan_sel_latched.
- FSM states:
  - IDLE: s_axis traffic is ignored. enable_i=1 latches chan_sel and pkt_len and moves to SYNC.
  - SYNC: discards input until s_axis_tvalid & s_axis_tlast, then moves to RUN on the next cycle. This aligns extraction to a channelizer frame boundary. enable_i=0 returns to IDLE.
  - RUN: each matching word is written to the FIFO as {tlast_bit, tdata}.
  - FLUSH (entered from RUN when enable_i=0): input is ignored.
    - If wr_cnt!=0, zero words {0,32'd0} are written whenever the FIFO is not full, until the packet completes. The final pad carries tlast_bit=1.
    - Once wr_cnt==0, move to IDLE. If wr_cnt is already 0 on entry, move to IDLE on the next cycle.
    - Output draining continues independently of the FSM state.
- Write-side packet counter wr_cnt (LEN_WIDTH bits):
  - Increments only on an actual FIFO write.
  - tlast_bit=1 when wr_cnt==pkt_len-1; wr_cnt then wraps to 0.
  - pkt_len=1 makes every word a tlast.
- Overflow: a matching word arriving in RUN while the FIFO is full is dropped.
  - The drop does not advance wr_cnt, so packets always hold exactly pkt_len written words.
  - ovf_cnt increments and saturates at 16'hFFFF.
  - ovf_cnt clears only on reset.
- FIFO: 2^FIFO_AW entries x (DATA_WIDTH+1) bits, registered read, output register, FWFT behaviour.
  - full/empty use an FIFO_AW+1-bit occupancy count.
  - A simultaneous write and read when full is allowed (read frees a slot in the same cycle).
  - A simultaneous write and read when empty is allowed.
  - Latency: a word written at cycle N into an empty FIFO presents m_axis_tvalid=1 at cycle N+2.
- Output: m_axis_tdata and m_axis_tlast are held stable while m_axis_tvalid=1 and m_axis_tready=0. A transfer occurs when tvalid & tready; back-to-back transfers run at 1 word/clk.
- Config change: chan_sel and pkt_len changes while busy_o=1 have no effect until the next IDLE->SYNC transition.
- Reset mid-operation: async assertion immediately clears the FIFO pointers, counters, FSM and outputs. Any partial packet is lost.

Decomposition:
- Package chan_extract_pkg holds:
  - FSM state encoding {IDLE, SYNC, RUN, FLUSH};
  - localparam FIFO_W = DATA_WIDTH+1;
  - OVF_MAX = 16'hFFFF.
- Sub-module chan_extract_fifo: FWFT synchronous FIFO with async active-low reset and parameters FIFO_AW and FIFO_W. The top-level holds the FSM, match logic, wr_cnt and ovf_cnt.

Test Plan:
- Basic extract: chan_sel=5, pkt_len=4, enable_i=1; a 2048-word frame ending in tlast, then 8 frames with tuser=index and tdata={index,frame#}. Expect exactly 2 packets of 4 words, tdata={16'd5,16'd1..8}, tlast on words 4 and 8, ovf_cnt=0.
- SYNC alignment: enable_i raised mid-frame at tuser=1000 with chan_sel=1500. The rest of that frame (including channel 1500) is discarded. The first output is channel 1500 of the next frame.
- Overflow: m_axis_tready=0, chan_sel=0, pkt_len=16, 1030 frames. Expect the FIFO to hold 1024 words and ovf_cnt=6. After tready=1, exactly 64 packets drain, each with tlast on every 16th word.
- Flush padding: pkt_len=10, enable_i dropped after 13 matched words. Expect packet 2 to carry 3 real words plus 7 zero words with tlast on the 7th pad, then busy_o=0.
- Back-pressure stability: toggle m_axis_tready with period 150 ns (50 ns high, 100 ns low). tdata and tlast must not change while tvalid=1 and tready=0, and no word may be lost or duplicated.
- Async reset: assert async_reset_n=0 mid-packet, between clock edges. All outputs go to 0 before the next edge, and s_axis_tready=1 on the first edge after release.
